instr_fetch_queue: RTL and testbench

Fetch-side consumer of the program counter unit. Converts each valid PC into an instruction-memory read, tracks in-flight reads, and buffers returned instructions with their PCs in an in-order queue toward decode. It returns `go` to the PC unit as a credit-based advance enable. On a taken branch, `flush` discards every buffered and in-flight instruction.

---
 rtl/instr_fetch_queue.sv | 237 +++++++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch-side consumer of the program counter unit. Each valid PC becomes one
// instruction-memory read. The PCs of in-flight reads are kept in a pending
// FIFO. Returned words are paired with their PC and queued in order toward
// decode. The block returns a credit-style advance enable (go) to the PC unit.
// A taken branch (flush) throws away every buffered and in-flight instruction.
// Late responses to flushed reads are absorbed by the drop counter.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   pc_in        current PC from the PC unit
//   pc_valid     pc_in is a fetchable address
//   go           PC unit may advance this cycle (combinational)
//   flush        branch redirect, same cycle the PC unit selects the target
//   imem_req     read request to instruction memory (combinational)
//   imem_addr    read address, equal to pc_in
//   imem_rvalid  read data returned (in order, latency >= 1, no backpressure)
//   imem_rdata   returned instruction word
//   instr_valid  head entry valid to decode (registered)
//   instr_ready  decode accepts the head entry
//   instr        head instruction (registered)
//   instr_pc     PC of the head instruction (registered)
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic                   pc_valid,
    output logic                   go,
    input  logic                   flush,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    // One extra bit so occ + outst can never wrap before the compare.
    typedef logic [CW:0]   sum_t;

    localparam sum_t DEPTH_LVL = sum_t'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PC_WIDTH-1:0]    pend_pc  [DEPTH];
    logic [INSTR_WIDTH-1:0] iq_instr [DEPTH];
    logic [PC_WIDTH-1:0]    iq_pc    [DEPTH];

    ptr_t pend_rd, pend_wr;
    ptr_t iq_rd, iq_wr;
    cnt_t occ;    // entries buffered in the instruction FIFO
    cnt_t outst;  // live reads whose data will be kept
    cnt_t drop;   // stale reads (issued before a flush) still to come back

    // Next-state values
    ptr_t                   pend_rd_n, pend_wr_n;
    ptr_t                   iq_rd_n, iq_wr_n;
    cnt_t                   occ_n, outst_n, drop_n;
    cnt_t                   occ_left;
    logic                   instr_valid_n;
    logic [INSTR_WIDTH-1:0] instr_n;
    logic [PC_WIDTH-1:0]    instr_pc_n;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    sum_t in_use;
    logic issue;
    logic rsp_legal;
    logic rsp_keep;
    logic rsp_drop;
    logic deq;
    logic [PC_WIDTH-1:0] rsp_pc;

    assign in_use = sum_t'(occ) + sum_t'(outst);

    // Stale reads held in drop are not counted here. New fetches may start
    // straight after a flush, and the stale data is filtered on return.
    assign go        = !rst && (in_use < DEPTH_LVL);
    assign issue     = pc_valid && go && !flush;
    assign imem_req  = issue;
    assign imem_addr = pc_in;

    // A response with nothing in flight is illegal. It is excluded from both
    // the keep and the drop paths, so it cannot corrupt the counters.
    assign rsp_legal = imem_rvalid && ((outst != '0) || (drop != '0));

    // Stale data always returns before live data, because the memory answers
    // in order. So drop is drained before any response is kept.
    assign rsp_drop  = imem_rvalid && (drop != '0) && !flush;
    assign rsp_keep  = imem_rvalid && (drop == '0) && (outst != '0) && !flush;
    assign deq       = instr_valid && instr_ready && !flush;
    assign rsp_pc    = pend_pc[pend_rd];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; an unassigned path would infer a latch.
        pend_rd_n     = pend_rd;
        pend_wr_n     = pend_wr;
        iq_rd_n       = iq_rd;
        iq_wr_n       = iq_wr;
        occ_n         = occ;
        outst_n       = outst;
        drop_n        = drop;
        occ_left      = occ;
        instr_valid_n = instr_valid;
        instr_n       = instr;
        instr_pc_n    = instr_pc;

        if (flush) begin
            // Every live read becomes stale. A response landing in this same
            // cycle is already the oldest of them, so it is used up at once.
            pend_rd_n     = '0;
            pend_wr_n     = '0;
            iq_rd_n       = '0;
            iq_wr_n       = '0;
            occ_n         = '0;
            outst_n       = '0;
            drop_n        = drop + outst - cnt_t'(rsp_legal);
            instr_valid_n = 1'b0;
        end else begin
            outst_n   = outst + cnt_t'(issue) - cnt_t'(rsp_keep);
            drop_n    = drop - cnt_t'(rsp_drop);
            pend_wr_n = pend_wr + ptr_t'(issue);
            pend_rd_n = pend_rd + ptr_t'(rsp_keep);
            iq_wr_n   = iq_wr + ptr_t'(rsp_keep);
            iq_rd_n   = iq_rd + ptr_t'(deq);
            occ_left  = occ - cnt_t'(deq);
            occ_n     = occ_left + cnt_t'(rsp_keep);

            // The registered head shows the entry at the new read pointer.
            // If the FIFO is empty once the pop is done, that entry is the one
            // being pushed now, and it is not yet in storage.
            if (occ_n != '0) begin
                instr_valid_n = 1'b1;
                if (rsp_keep && (occ_left == '0)) begin
                    instr_n    = imem_rdata;
                    instr_pc_n = rsp_pc;
                end else begin
                    instr_n    = iq_instr[iq_rd_n];
                    instr_pc_n = iq_pc[iq_rd_n];
                end
            end else begin
                // Hold instr/instr_pc and drop only the valid flag.
                instr_valid_n = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_rd     <= '0;
            pend_wr     <= '0;
            iq_rd       <= '0;
            iq_wr       <= '0;
            occ         <= '0;
            outst       <= '0;
            drop        <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before the edge, whatever the statement order.
            pend_rd     <= pend_rd_n;
            pend_wr     <= pend_wr_n;
            iq_rd       <= iq_rd_n;
            iq_wr       <= iq_wr_n;
            occ         <= occ_n;
            outst       <= outst_n;
            drop        <= drop_n;
            instr_valid <= instr_valid_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    // NOTE: storage arrays have no reset. The counters and pointers alone
    // decide which entries are meaningful, and the head output has its own
    // reset registers.
    always_ff @(posedge clk) begin
        if (issue) begin
            pend_pc[pend_wr] <= pc_in;
        end
        if (rsp_keep) begin
            iq_instr[iq_wr] <= imem_rdata;
            iq_pc[iq_wr]    <= rsp_pc;
        end
    end

    // -----------------------------------------------------------------------
    // Checks
    // -----------------------------------------------------------------------
    // The memory must only answer reads it was actually given.
    illegal_rsp_a: assert property (
        @(posedge clk) disable iff (rst)
        imem_rvalid |-> ((outst != '0) || (drop != '0))
    );

    // Credit accounting: buffered plus live reads never exceed the queue.
    credit_bound_a: assert property (
        @(posedge clk) disable iff (rst)
        in_use <= DEPTH_LVL
    );

    // The registered valid flag always agrees with the occupancy counter.
    valid_tracks_occ_a: assert property (
        @(posedge clk) disable iff (rst)
        instr_valid == (occ != '0)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// Testbench for instr_fetch_queue.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge. The bench models the instruction memory: each request
// returns ~addr after a fixed latency.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

    localparam int PW = 32;
    localparam int IW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pc_in;
    logic          pc_valid;
    logic          go;
    logic          flush;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [PW-1:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .PC_WIDTH   (PW),
        .INSTR_WIDTH(IW),
        .DEPTH      (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .go         (go),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    int total = 0;
    int bad   = 0;
    int cyc;
    int lat;
    int req_cnt;
    int deq_cnt;
    bit sb_on;

    typedef struct {
        logic [PW-1:0] addr;
        int            due;
    } mreq_t;

    mreq_t         mq[$];
    logic [PW-1:0] exp_q[$];

    typedef struct {
        logic          v;
        logic [PW-1:0] pc;
        logic          rdy;
        logic          fl;
        logic          e_go;
        logic          e_req;
        logic          e_val;
        logic [PW-1:0] e_pc;
    } vec_t;

    vec_t t1[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] rdata_of(input logic [PW-1:0] a);
        return ~a;
    endfunction

    // Drive this cycle's memory response from the request list.
    task automatic mem_drive();
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rdata_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    // Set the inputs for the current cycle and move to the sampling point.
    task automatic apply(input logic v, input logic [PW-1:0] pc, input logic rdy, input logic fl);
        pc_valid    = v;
        pc_in       = pc;
        instr_ready = rdy;
        flush       = fl;
        @(negedge clk);
    endtask

    // Record requests and dequeues for this cycle, then move to the next cycle.
    task automatic finish_cycle();
        logic [PW-1:0] e;
        if (imem_req === 1'b1) begin
            mq.push_back('{addr: imem_addr, due: cyc + lat});
            req_cnt++;
            if (sb_on) exp_q.push_back(imem_addr);
        end
        if (sb_on && instr_valid === 1'b1 && instr_ready && !flush) begin
            deq_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_queue_has_entry", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e);
                check("sb_instr", instr, rdata_of(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        pc_valid    = 1'b0;
        pc_in       = '0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mq.delete();
        exp_q.delete();
        sb_on = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc     = 0;
        req_cnt = 0;
        deq_cnt = 0;
        mem_drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] pc;
        logic          r;
        logic          rdy;

        // Test 1: PCs 0,4,8,12 with latency 1 and decode always ready.
        //        v  pc  rdy fl  go req val pc
        t1[0] = '{1, 'h0,  1, 0, 1, 1, 0, 'h0};
        t1[1] = '{1, 'h4,  1, 0, 1, 1, 0, 'h0};
        t1[2] = '{1, 'h8,  1, 0, 1, 1, 1, 'h0};
        t1[3] = '{1, 'hC,  1, 0, 1, 1, 1, 'h4};
        t1[4] = '{0, 'h10, 1, 0, 1, 0, 1, 'h8};
        t1[5] = '{0, 'h10, 1, 0, 1, 0, 1, 'hC};
        t1[6] = '{0, 'h10, 1, 0, 1, 0, 0, 'h0};

        // Reset values, with pc_valid high during reset.
        cyc = 0; lat = 1; req_cnt = 0; deq_cnt = 0; sb_on = 1'b0;
        rst = 1'b1; pc_valid = 1'b1; pc_in = 'h40; flush = 1'b0;
        instr_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        #12;
        check("rst_go", go, 0);
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(t1[i].v, t1[i].pc, t1[i].rdy, t1[i].fl);
            check("t1_go", go, t1[i].e_go);
            check("t1_req", imem_req, t1[i].e_req);
            if (t1[i].e_req) check("t1_addr", imem_addr, t1[i].pc);
            check("t1_valid", instr_valid, t1[i].e_val);
            if (t1[i].e_val) begin
                check("t1_instr_pc", instr_pc, t1[i].e_pc);
                check("t1_instr", instr, rdata_of(t1[i].e_pc));
            end
            finish_cycle();
        end

        // Test 2: credit limit, decode stalled, latency 2.
        do_reset();
        lat = 2;
        pc  = 'h40;
        for (int k = 0; k < 7; k++) begin
            apply(1'b1, pc, 1'b0, 1'b0);
            r = imem_req;
            finish_cycle();
            if (r) pc += 4;
        end
        apply(1'b1, pc, 1'b1, 1'b0);
        check("full_req_cnt", req_cnt, 4);
        check("full_go", go, 0);
        check("full_req", imem_req, 0);
        check("full_head_pc", instr_pc, 'h40);
        finish_cycle();
        apply(1'b1, pc, 1'b0, 1'b0);
        check("credit_go", go, 1);
        check("credit_req", imem_req, 1);
        check("credit_addr", imem_addr, 'h50);
        check("credit_head_pc", instr_pc, 'h44);
        finish_cycle();
        pc += 4;
        apply(1'b1, pc, 1'b0, 1'b0);
        check("refull_go", go, 0);
        check("refull_req", imem_req, 0);
        finish_cycle();
        check("credit_req_cnt", req_cnt, 5);

        // Test 3: flush with outst=2, occ=1, no response in the flush cycle.
        do_reset();
        lat = 3;
        apply(1'b1, 'h0, 1'b0, 1'b0); finish_cycle();
        apply(1'b0, 'h4, 1'b0, 1'b0); finish_cycle();
        apply(1'b1, 'h4, 1'b0, 1'b0); finish_cycle();
        apply(1'b1, 'h8, 1'b0, 1'b0); finish_cycle();
        apply(1'b1, 'h100, 1'b0, 1'b1);
        check("f1_outst", dut.outst, 2);
        check("f1_occ", dut.occ, 1);
        check("f1_req_suppressed", imem_req, 0);
        finish_cycle();
        apply(1'b1, 'h100, 1'b0, 1'b0);
        check("f1_valid_after", instr_valid, 0);
        check("f1_go_after", go, 1);
        check("f1_drop", dut.drop, 2);
        check("f1_req_target", imem_req, 1);
        check("f1_addr_target", imem_addr, 'h100);
        finish_cycle();
        apply(1'b0, 'h104, 1'b0, 1'b0);
        check("f1_drop_1", dut.drop, 1);
        check("f1_valid_c6", instr_valid, 0);
        finish_cycle();
        apply(1'b0, 'h104, 1'b0, 1'b0);
        check("f1_drop_0", dut.drop, 0);
        check("f1_valid_c7", instr_valid, 0);
        finish_cycle();
        apply(1'b0, 'h104, 1'b0, 1'b0);
        check("f1_valid_c8", instr_valid, 0);
        finish_cycle();
        apply(1'b0, 'h104, 1'b0, 1'b0);
        check("f1_kept_valid", instr_valid, 1);
        check("f1_kept_pc", instr_pc, 'h100);
        check("f1_kept_instr", instr, rdata_of('h100));
        finish_cycle();

        // Test 4: flush coincident with a response, outst=3.
        do_reset();
        lat = 3;
        apply(1'b1, 'h0, 1'b1, 1'b0); finish_cycle();
        apply(1'b1, 'h4, 1'b1, 1'b0); finish_cycle();
        apply(1'b1, 'h8, 1'b1, 1'b0); finish_cycle();
        apply(1'b1, 'h200, 1'b1, 1'b1);
        check("f2_outst", dut.outst, 3);
        check("f2_req_suppressed", imem_req, 0);
        finish_cycle();
        apply(1'b1, 'h200, 1'b1, 1'b0);
        check("f2_drop", dut.drop, 2);
        check("f2_valid_after", instr_valid, 0);
        check("f2_go_after", go, 1);
        check("f2_addr", imem_addr, 'h200);
        check("f2_req", imem_req, 1);
        finish_cycle();
        apply(1'b1, 'h204, 1'b1, 1'b0);
        check("f2_drop_1", dut.drop, 1);
        check("f2_valid_c5", instr_valid, 0);
        finish_cycle();
        apply(1'b0, 'h208, 1'b1, 1'b0);
        check("f2_drop_0", dut.drop, 0);
        check("f2_valid_c6", instr_valid, 0);
        finish_cycle();
        apply(1'b0, 'h208, 1'b1, 1'b0);
        check("f2_valid_c7", instr_valid, 0);
        finish_cycle();
        apply(1'b0, 'h208, 1'b1, 1'b0);
        check("f2_first_valid", instr_valid, 1);
        check("f2_first_pc", instr_pc, 'h200);
        check("f2_first_instr", instr, rdata_of('h200));
        finish_cycle();
        apply(1'b0, 'h208, 1'b1, 1'b0);
        check("f2_second_pc", instr_pc, 'h204);
        finish_cycle();
        apply(1'b0, 'h208, 1'b1, 1'b0);
        check("f2_drained", instr_valid, 0);
        finish_cycle();

        // Test 5: push and pop together at occ=DEPTH-1 across pointer wraps.
        do_reset();
        lat   = 1;
        sb_on = 1'b1;
        pc    = 'h1000;
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, pc, 1'b0, 1'b0);
            r = imem_req;
            finish_cycle();
            if (r) pc += 4;
        end
        for (int k = 0; k < 40; k++) begin
            rdy = imem_rvalid;
            apply(1'b1, pc, rdy, 1'b0);
            check("wrap_occ", dut.occ, 3);
            r = imem_req;
            finish_cycle();
            if (r) pc += 4;
        end
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            apply(1'b0, pc, 1'b1, 1'b0);
            finish_cycle();
        end
        check("wrap_all_consumed", 64'(exp_q.size()), 0);
        check("wrap_deq_eq_req", deq_cnt, req_cnt);
        check("wrap_min_traffic", 64'(deq_cnt >= 3 * D + 4), 1);
        sb_on = 1'b0;

        // Test 6: reset asserted mid-burst with occ=2, outst=1.
        do_reset();
        lat = 1;
        pc  = 'h80;
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, pc, 1'b0, 1'b0);
            r = imem_req;
            finish_cycle();
            if (r) pc += 4;
        end
        apply(1'b1, pc, 1'b0, 1'b0);
        check("mid_occ", dut.occ, 2);
        check("mid_outst", dut.outst, 1);
        check("mid_valid", instr_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_go", go, 0);
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_instr", instr, 0);
        check("mid_rst_instr_pc", instr_pc, 0);
        do_reset();
        apply(1'b1, 'h300, 1'b1, 1'b0);
        check("restart_req", imem_req, 1);
        check("restart_addr", imem_addr, 'h300);
        finish_cycle();
        apply(1'b0, 'h304, 1'b1, 1'b0);
        check("restart_valid_c1", instr_valid, 0);
        finish_cycle();
        apply(1'b0, 'h304, 1'b1, 1'b0);
        check("restart_valid", instr_valid, 1);
        check("restart_pc", instr_pc, 'h300);
        check("restart_instr", instr, rdata_of('h300));
        finish_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
